noc_packet_gen_param: RTL
=========================

Name: noc_packet_gen_param

Overview:
- Parametrised traffic source for one mesh node.
- Builds wormhole packets of PKT_LEN flits (head, body…, tail) and pushes them into the router injection port over a write_req/write_req_ack handshake.
- Supports uniform-random or fixed destination, programmable inter-packet gap, full back-pressure and graceful end-of-simulation stop.
- Payload and destinations come from a synthesizable LFSR, so runs are deterministic.

Parameters:
- FLIT_W, 64: flit width; must be ≥ 2+6*COORD_W+1.
- COORD_W, 3: width of each X/Y coordinate.
- PKT_LEN, 4: flits per packet; must be ≥ 2.
- IDLE_GAP, 9: idle cycles after reset and after each tail before the next packet may start; 0 is legal.
- SEED, 32'h1ACE_B00C: LFSR base seed.

Ports:
- clk, input, 1: clock; all logic on the rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = reset).
- end_sim, input, 1: stop request.
- j_e, input, 1: injection enable.
- mode, input, 1: 0 = uniform-random destination, 1 = fixed destination.
- fix_dst_X, input, COORD_W: fixed-mode destination X.
- fix_dst_Y, input, COORD_W: fixed-mode destination Y.
- src_X, input, COORD_W: own X coordinate; static after reset.
- src_Y, input, COORD_W: own Y coordinate; static after reset.
- Flit, output, FLIT_W: flit to the router; registered.
- write_req, output, 1: Flit valid; registered.
- write_req_ack, input, 1: router accepts the flit this cycle.
- busy, output, 1: high while a packet is in flight.
- pkt_count, output, 32: tails accepted since reset; wraps.

Behaviour:
- Reset (reset=0, async): state GAP with gap counter 0; Flit=0, write_req=0, busy=0, pkt_count=0, sequence counter seq=0, LFSR = SEED ^ {src_Y,src_X} (forced to 1 if the result is 0).
- LFSR: 32-bit Galois, taps 32'h8020_0003, shifts right.
  - Advances every cycle outside reset.
  - rnd denotes its current value.
- Flit format:
  - [FLIT_W-1:FLIT_W-2] = type: head 2'b11, body 2'b01, tail 2'b10.
  - [4*COORD_W-1:0] = {dst_Y,dst_X,src_Y,src_X} in every flit.
  - Head middle field = {seq, src_Y, src_X}, with seq truncated to fit.
  - Body/tail middle field = {rnd,rnd} truncated to fit.
- States:
  - GAP: count IDLE_GAP cycles → WAIT_EN; goes directly when IDLE_GAP=0.
  - WAIT_EN: if end_sim → STOP; else if j_e → SEND, with idx=0 and the destination latched this cycle.
  - SEND: see handshake and sequencing below.
  - STOP: terminal until reset; write_req=0.
- Destination selection:
  - mode=1: (fix_dst_X, fix_dst_Y).
  - mode=0: dst_X=rnd[COORD_W-1:0], dst_Y=rnd[2*COORD_W-1:COORD_W].
  - In either mode, if dst equals src, dst_X bit 0 is inverted. A packet never targets its own node.
- Latency: head appears (write_req=1) the cycle after j_e is sampled high in WAIT_EN.
- Handshake:
  - write_req and Flit stay constant until a rising edge where write_req_ack=1.
  - On that edge the next flit is loaded and write_req stays 1 (back-to-back, one flit per cycle at full rate).
  - write_req_ack while write_req=0 is ignored.
  - Flit payload is sampled from rnd only when the flit is loaded.
- Sequencing:
  - Head accept → seq+1.
  - Tail accept → pkt_count+1, write_req=0, busy=0, then GAP; goes to STOP instead if end_sim has been seen at any point during the packet.
- busy is 1 from head load until tail accept.
- Mid-packet:
  - j_e changes are ignored.
  - end_sim never truncates a packet.
  - mode and fix_dst changes do not affect the packet in flight.
- end_sim in GAP → STOP immediately.
- seq counter width is FLIT_W-2-6*COORD_W and wraps. pkt_count wraps at 2^32.
- Reset asserted mid-packet clears write_req asynchronously; the partial packet is abandoned.

Test Plan:
- Reset release, j_e=1, ack tied 1, defaults, src=(2,5) → write_req rises 10 cycles after reset release. Then 4 consecutive flits with types 11,01,01,10, identical low 12 bits, and head [61:12]={44'd0,6'd42}. pkt_count=1 after the tail.
- Ack held 0 for 5 cycles on the second body flit → Flit and write_req stable for all 5 cycles. No flit lost or duplicated; total 4 accepts per packet.
- mode=1, fix_dst = src = (3,3) → dst=(2,3) in all flits. mode=1, fix_dst=(0,7) → dst=(0,7).
- end_sim pulsed during the first body flit → the packet completes through the tail, then write_req stays 0 forever and pkt_count is frozen.
- reset driven 0 while write_req=1 mid-packet → write_req=0 without waiting for a clock edge. After release, the first head carries seq=0.
- PKT_LEN=2, IDLE_GAP=0, 1000 packets with random ack and mode=0 → head/tail only, no self-destination, pkt_count=1000, seq values 0..999.

Source files
------------

// File: rtl/noc_packet_gen_param.sv
// Purpose : wormhole packet traffic source for one mesh node (head/body/tail flits, LFSR payload).
// Latency : head flit presented the cycle after j_e is sampled high in WAIT_EN; then one flit per accept.
// Backpres: Flit/write_req hold until a rising edge with write_req_ack=1; nothing is dropped or repeated.
//
// Ports:
//   clk, reset (async, active-low)    clock and reset
//   end_sim, j_e, mode                stop request, injection enable, destination mode (0 random, 1 fixed)
//   fix_dst_X/Y, src_X/Y              fixed destination and own coordinates (src static after reset)
//   Flit, write_req, write_req_ack    registered flit + valid, router accept
//   busy, pkt_count                   packet in flight, tails accepted since reset (wraps)
module noc_packet_gen_param #(
    parameter int          FLIT_W   = 64,
    parameter int          COORD_W  = 3,
    parameter int          PKT_LEN  = 4,
    parameter int          IDLE_GAP = 9,
    parameter logic [31:0] SEED     = 32'h1ACE_B00C
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               end_sim,
    input  logic               j_e,
    input  logic               mode,
    input  logic [COORD_W-1:0] fix_dst_X,
    input  logic [COORD_W-1:0] fix_dst_Y,
    input  logic [COORD_W-1:0] src_X,
    input  logic [COORD_W-1:0] src_Y,
    output logic [FLIT_W-1:0]  Flit,
    output logic               write_req,
    input  logic               write_req_ack,
    output logic               busy,
    output logic [31:0]        pkt_count
);

    // Field geometry: type(2) | middle(MID_W) | dst_Y dst_X src_Y src_X (4*COORD_W)
    localparam int MID_W = FLIT_W - 2 - 4 * COORD_W;
    localparam int SEQ_W = FLIT_W - 2 - 6 * COORD_W;
    localparam int IDX_W = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam int GAP_LAST = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;

    localparam logic [GAP_W-1:0] GAP_LAST_C = GAP_LAST[GAP_W-1:0];
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(PKT_LEN - 1);

    localparam logic [1:0]  TYPE_HEAD = 2'b11;
    localparam logic [1:0]  TYPE_BODY = 2'b01;
    localparam logic [1:0]  TYPE_TAIL = 2'b10;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_GAP,
        ST_WAIT_EN,
        ST_SEND,
        ST_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [31:0]         pkt_cnt_q, pkt_cnt_d;
    logic [31:0]         lfsr_q, lfsr_d;
    logic [FLIT_W-1:0]   flit_q, flit_d;
    logic                write_req_q, write_req_d;
    logic                busy_q, busy_d;
    logic                stop_seen_q, stop_seen_d;
    logic [COORD_W-1:0]  dst_x_q, dst_x_d;
    logic [COORD_W-1:0]  dst_y_q, dst_y_d;

    logic [31:0]         seed_mix;
    logic [MID_W-1:0]    rnd_mid;
    logic [COORD_W-1:0]  dst_x_sel;
    logic [COORD_W-1:0]  dst_y_sel;
    logic [IDX_W-1:0]    idx_nxt;

    // Per-node seed so neighbouring generators do not emit identical streams.
    // src_X/src_Y must already be stable while reset is asserted.
    assign seed_mix = SEED ^ {{(32 - 2 * COORD_W){1'b0}}, src_Y, src_X};
    assign idx_nxt  = idx_q + 1'b1;

    // {rnd,rnd,...} truncated to the middle field width.
    always_comb begin
        rnd_mid = '0;
        for (int b = 0; b < MID_W; b++) begin
            rnd_mid[b] = lfsr_q[b % 32];
        end
    end

    // Destination candidate for the packet that would start this cycle.
    // Flipping dst_X bit 0 on a self-hit guarantees a different node in both modes.
    always_comb begin
        dst_x_sel = mode ? fix_dst_X : lfsr_q[COORD_W-1:0];
        dst_y_sel = mode ? fix_dst_Y : lfsr_q[2*COORD_W-1:COORD_W];
        if (dst_x_sel == src_X && dst_y_sel == src_Y) begin
            dst_x_sel[0] = ~dst_x_sel[0];
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        idx_d       = idx_q;
        seq_d       = seq_q;
        pkt_cnt_d   = pkt_cnt_q;
        flit_d      = flit_q;
        write_req_d = write_req_q;
        busy_d      = busy_q;
        stop_seen_d = stop_seen_q;
        dst_x_d     = dst_x_q;
        dst_y_d     = dst_y_q;
        // Galois right-shift LFSR, free-running every cycle
        lfsr_d      = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);

        unique case (state_q)
            ST_GAP: begin
                if (end_sim) begin
                    state_d = ST_STOP;
                end else if (IDLE_GAP == 0 || gap_q == GAP_LAST_C) begin
                    state_d = ST_WAIT_EN;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            ST_WAIT_EN: begin
                if (end_sim) begin
                    state_d = ST_STOP;
                end else if (j_e) begin
                    state_d     = ST_SEND;
                    idx_d       = '0;
                    dst_x_d     = dst_x_sel;
                    dst_y_d     = dst_y_sel;
                    write_req_d = 1'b1;
                    busy_d      = 1'b1;
                    stop_seen_d = 1'b0;
                    flit_d      = {TYPE_HEAD, seq_q, src_Y, src_X,
                                   dst_y_sel, dst_x_sel, src_Y, src_X};
                end
            end

            ST_SEND: begin
                // A stop request is remembered and honoured only after the tail.
                if (end_sim) begin
                    stop_seen_d = 1'b1;
                end
                if (write_req_ack) begin
                    if (idx_q == '0) begin
                        seq_d = seq_q + 1'b1;
                    end
                    if (idx_q == IDX_LAST) begin
                        pkt_cnt_d   = pkt_cnt_q + 32'd1;
                        write_req_d = 1'b0;
                        busy_d      = 1'b0;
                        gap_d       = '0;
                        state_d     = (stop_seen_q || end_sim) ? ST_STOP : ST_GAP;
                    end else begin
                        idx_d  = idx_nxt;
                        flit_d = {(idx_nxt == IDX_LAST) ? TYPE_TAIL : TYPE_BODY,
                                  rnd_mid, dst_y_q, dst_x_q, src_Y, src_X};
                    end
                end
            end

            ST_STOP: begin
                write_req_d = 1'b0;
                busy_d      = 1'b0;
            end

            default: begin
                state_d = ST_STOP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_GAP;
            gap_q       <= '0;
            idx_q       <= '0;
            seq_q       <= '0;
            pkt_cnt_q   <= '0;
            lfsr_q      <= (seed_mix == 32'd0) ? 32'd1 : seed_mix;
            flit_q      <= '0;
            write_req_q <= 1'b0;
            busy_q      <= 1'b0;
            stop_seen_q <= 1'b0;
            dst_x_q     <= '0;
            dst_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            idx_q       <= idx_d;
            seq_q       <= seq_d;
            pkt_cnt_q   <= pkt_cnt_d;
            lfsr_q      <= lfsr_d;
            flit_q      <= flit_d;
            write_req_q <= write_req_d;
            busy_q      <= busy_d;
            stop_seen_q <= stop_seen_d;
            dst_x_q     <= dst_x_d;
            dst_y_q     <= dst_y_d;
        end
    end

    assign Flit      = flit_q;
    assign write_req = write_req_q;
    assign busy      = busy_q;
    assign pkt_count = pkt_cnt_q;

endmodule
